edge_detector_multi: RTL and testbench

EDGE_DETECTOR_MULTI -- requirements
Module: edge_detector_multi

---
 rtl/edge_detector_multi.sv | 69 ++++++
 tb/tb_edge_detector_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/edge_detector_multi.sv
// Multi-channel filtered edge detector.
// Per-channel debounce, edge qualify, sticky pending/overrun and irq.
module edge_detector_multi #(
  parameter int CHANNELS = 4,
  parameter int FILTER   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   overrun,
  output logic                  irq
);

  localparam logic [3:0] LAST = 4'(FILTER - 1);

  logic [CHANNELS-1:0] stab;
  logic [3:0]          cnt [CHANNELS];
  logic [CHANNELS-1:0] acc;
  logic [CHANNELS-1:0] qual;

  // acc: sample completes a differing run; qual: mode allows that edge
  always_comb begin
    acc  = '0;
    qual = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (update && (level[i] != stab[i]) && (cnt[i] == LAST)) begin
        acc[i]  = 1'b1;
        qual[i] = level[i] ? mode[2*i] : mode[2*i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stab    <= '0;
      tick    <= '0;
      pending <= '0;
      overrun <= '0;
      irq     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (update) begin
          if (level[i] == stab[i]) begin
            cnt[i] <= '0;
          end else if (acc[i]) begin
            stab[i] <= level[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end
      end
      tick    <= qual;
      pending <= qual | (pending & ~clear);
      overrun <= (qual & pending & ~clear)
               | (overrun & ~clear);
      irq     <= |pending;
    end
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi.
// FILTER=1 table plus FILTER=3 / FILTER=2 sequences.
module tb_edge_detector_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       update;
  logic [3:0] level;
  logic [7:0] mode;
  logic [3:0] clear;

  logic [3:0] tk1, pd1, ov1;
  logic [3:0] tk3, pd3, ov3;
  logic [3:0] tk2, pd2, ov2;
  logic       iq1, iq3, iq2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  edge_detector_multi #(.CHANNELS(4), .FILTER(1)) d1 (
    .clk(clk), .reset(reset), .update(update),
    .level(level), .mode(mode), .clear(clear),
    .tick(tk1), .pending(pd1), .overrun(ov1), .irq(iq1)
  );

  edge_detector_multi #(.CHANNELS(4), .FILTER(3)) d3 (
    .clk(clk), .reset(reset), .update(update),
    .level(level), .mode(mode), .clear(clear),
    .tick(tk3), .pending(pd3), .overrun(ov3), .irq(iq3)
  );

  edge_detector_multi #(.CHANNELS(4), .FILTER(2)) d2 (
    .clk(clk), .reset(reset), .update(update),
    .level(level), .mode(mode), .clear(clear),
    .tick(tk2), .pending(pd2), .overrun(ov2), .irq(iq2)
  );

  typedef struct {
    logic       rst;
    logic       upd;
    logic [3:0] lvl;
    logic [7:0] md;
    logic [3:0] clr;
    logic [3:0] tk;
    logic [3:0] pd;
    logic [3:0] ov;
    logic       iq;
  } vec_t;

  vec_t tv[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic u,
                       input logic [3:0] l,
                       input logic [7:0] m,
                       input logic [3:0] c);
    reset  = r;
    update = u;
    level  = l;
    mode   = m;
    clear  = c;
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'h0, 8'h55, 4'h0);

    // rst upd lvl md clr | tick pend ovr irq
    tv.push_back('{0,0,4'h0,8'h55,4'h0, 4'h0,4'h0,4'h0,0});
    tv.push_back('{1,1,4'h0,8'h55,4'h0, 4'h0,4'h0,4'h0,0});
    tv.push_back('{1,1,4'h1,8'h55,4'h0, 4'h1,4'h1,4'h0,0});
    tv.push_back('{1,1,4'h1,8'h55,4'h0, 4'h0,4'h1,4'h0,1});
    tv.push_back('{1,1,4'h3,8'h55,4'h0, 4'h2,4'h3,4'h0,1});
    tv.push_back('{1,1,4'h0,8'h55,4'h0, 4'h0,4'h3,4'h0,1});
    tv.push_back('{1,1,4'h1,8'h55,4'h0, 4'h1,4'h3,4'h1,1});
    tv.push_back('{1,1,4'h0,8'h55,4'hF, 4'h0,4'h0,4'h0,1});
    tv.push_back('{1,1,4'h0,8'h55,4'h0, 4'h0,4'h0,4'h0,0});
    tv.push_back('{1,1,4'h1,8'h55,4'h1, 4'h1,4'h1,4'h0,0});
    tv.push_back('{1,1,4'h0,8'h55,4'h0, 4'h0,4'h1,4'h0,1});
    tv.push_back('{1,1,4'h1,8'h55,4'h1, 4'h1,4'h1,4'h0,1});
    tv.push_back('{1,0,4'h0,8'h55,4'h0, 4'h0,4'h1,4'h0,1});
    tv.push_back('{1,0,4'h0,8'hAA,4'h0, 4'h0,4'h1,4'h0,1});
    tv.push_back('{1,1,4'h0,8'hAA,4'h0, 4'h1,4'h1,4'h1,1});
    tv.push_back('{1,1,4'h1,8'h00,4'hF, 4'h0,4'h0,4'h0,1});
    tv.push_back('{1,1,4'h0,8'hAA,4'h0, 4'h1,4'h1,4'h0,0});
    tv.push_back('{1,1,4'h1,8'hFF,4'h0, 4'h1,4'h1,4'h1,1});
    tv.push_back('{1,1,4'h0,8'hFF,4'h0, 4'h1,4'h1,4'h1,1});
    tv.push_back('{1,1,4'h1,8'hFF,4'h0, 4'h1,4'h1,4'h1,1});
    tv.push_back('{0,1,4'h0,8'hFF,4'h0, 4'h0,4'h0,4'h0,0});
    tv.push_back('{1,1,4'hF,8'h55,4'h0, 4'hF,4'hF,4'h0,0});
    tv.push_back('{1,1,4'hF,8'h55,4'hF, 4'h0,4'h0,4'h0,1});
    tv.push_back('{1,1,4'hF,8'h55,4'h0, 4'h0,4'h0,4'h0,0});

    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].upd, tv[k].lvl,
            tv[k].md, tv[k].clr);
      step();
      chk($sformatf("v%0d tick", k), tk1, tv[k].tk);
      chk($sformatf("v%0d pend", k), pd1, tv[k].pd);
      chk($sformatf("v%0d ovr", k), ov1, tv[k].ov);
      chk($sformatf("v%0d irq", k), {3'b0, iq1},
          {3'b0, tv[k].iq});
    end

    // FILTER=3: short run broken, then run with update gaps
    drive(1'b0, 1'b0, 4'h0, 8'h55, 4'h0);
    step();
    chk("f3 rst tick", tk3, 4'h0);
    drive(1'b1, 1'b1, 4'h1, 8'h55, 4'h0);
    step();
    chk("f3 s1", tk3, 4'h0);
    step();
    chk("f3 s2", tk3, 4'h0);
    level = 4'h0;
    step();
    chk("f3 break", tk3, 4'h0);
    level = 4'h1;
    step();
    chk("f3 r1", tk3, 4'h0);
    update = 1'b0;
    level  = 4'h0;
    step();
    chk("f3 gap1", tk3, 4'h0);
    update = 1'b1;
    level  = 4'h1;
    step();
    chk("f3 r2", tk3, 4'h0);
    update = 1'b0;
    step();
    chk("f3 gap2", tk3, 4'h0);
    update = 1'b1;
    step();
    chk("f3 r3 tick", tk3, 4'h1);
    chk("f3 r3 pend", pd3, 4'h1);
    update = 1'b0;
    step();
    chk("f3 one-shot", tk3, 4'h0);
    chk("f3 irq", {3'b0, iq3}, 4'h1);

    // FILTER=3: reset drops an in-flight run
    drive(1'b0, 1'b0, 4'h0, 8'h55, 4'h0);
    step();
    drive(1'b1, 1'b1, 4'h2, 8'h55, 4'h0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("f3 mid rst pend", pd3, 4'h0);
    reset = 1'b1;
    step();
    chk("f3 rerun1", tk3, 4'h0);
    step();
    chk("f3 rerun2", tk3, 4'h0);
    step();
    chk("f3 rerun3", tk3, 4'h2);

    // FILTER=2: levels high out of reset
    drive(1'b0, 1'b1, 4'hF, 8'h55, 4'h0);
    step();
    chk("f2 rst tick", tk2, 4'h0);
    reset = 1'b1;
    step();
    chk("f2 s1", tk2, 4'h0);
    step();
    chk("f2 s2 tick", tk2, 4'hF);
    chk("f2 s2 pend", pd2, 4'hF);
    step();
    chk("f2 after", tk2, 4'h0);
    chk("f2 irq", {3'b0, iq2}, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
